wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Two-master Wishbone arbiter sharing one slave port. Alternates
//               ties, passes the owner's request and response through with no
//               added latency, and aborts a granted strobe that waits TIMEOUT
//               cycles without an acknowledge by signalling err for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  // master 0 (management SoC)
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  // master 1 (logic-analyzer debug master)
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  // shared slave
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  // status
  output logic [1:0]  grant_o,
  output logic        timeout_irq_o,
  output logic [7:0]  timeout_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_owner;   // master granted most recently; loses the next tie
  logic [7:0]  r_timer;        // cycles the owner's strobe has waited for ack
  logic [7:0]  r_timeout_cnt;

  logic        w_req0;
  logic        w_req1;
  logic        w_own_stb;
  logic        w_expired;

  assign w_req0    = m0_cyc_i & m0_stb_i;
  assign w_req1    = m1_cyc_i & m1_stb_i;
  assign w_own_stb = ((r_state == ST_OWN0) & m0_stb_i) | ((r_state == ST_OWN1) & m1_stb_i);
  // An ack in the same cycle as expiry wins, so expiry needs ack low.
  assign w_expired = (r_timer == TIMEOUT) & ~s_ack_i;

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: alternate on ties, release on cyc drop, abort on timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) begin
          w_next = r_last_owner ? ST_OWN0 : ST_OWN1;
        end else if (w_req0) begin
          w_next = ST_OWN0;
        end else if (w_req1) begin
          w_next = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!m0_cyc_i) begin
          w_next = ST_IDLE;
        end else if (w_expired) begin
          w_next = ST_ERR;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i) begin
          w_next = ST_IDLE;
        end else if (w_expired) begin
          w_next = ST_ERR;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Owner history and ack-wait timer; the timer restarts on every new grant.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_last_owner <= 1'b1;
      r_timer      <= 8'd0;
    end else if (r_state == ST_IDLE && w_next == ST_OWN0) begin
      r_last_owner <= 1'b0;
      r_timer      <= 8'd0;
    end else if (r_state == ST_IDLE && w_next == ST_OWN1) begin
      r_last_owner <= 1'b1;
      r_timer      <= 8'd0;
    end else if (r_state == ST_OWN0 || r_state == ST_OWN1) begin
      if (s_ack_i) begin
        r_timer <= 8'd0;
      end else if (w_own_stb && r_timer != 8'hFF) begin
        r_timer <= r_timer + 8'd1;
      end
    end
  end

  // Saturating count of timeouts, bumped on the edge that enters ERR.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_timeout_cnt <= 8'd0;
    end else if (w_next == ST_ERR && r_state != ST_ERR && r_timeout_cnt != 8'hFF) begin
      r_timeout_cnt <= r_timeout_cnt + 8'd1;
    end
  end

  assign timeout_cnt_o = r_timeout_cnt;

  // Output steering: only the owner is connected; IDLE/ERR drive zeros.
  always_comb begin
    s_cyc_o       = 1'b0;
    s_stb_o       = 1'b0;
    s_we_o        = 1'b0;
    s_sel_o       = 4'd0;
    s_adr_o       = 32'd0;
    s_dat_o       = 32'd0;
    m0_ack_o      = 1'b0;
    m0_err_o      = 1'b0;
    m0_dat_o      = 32'd0;
    m1_ack_o      = 1'b0;
    m1_err_o      = 1'b0;
    m1_dat_o      = 32'd0;
    grant_o       = 2'b00;
    timeout_irq_o = 1'b0;
    case (r_state)
      ST_OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
        m0_dat_o = s_dat_i;
        grant_o  = 2'b01;
      end
      ST_OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
        m1_dat_o = s_dat_i;
        grant_o  = 2'b10;
      end
      ST_ERR: begin
        timeout_irq_o = 1'b1;
        if (r_last_owner) begin
          m1_err_o = 1'b1;
        end else begin
          m0_err_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter (TIMEOUT = 4).
//               Expected master responses are queued when a transfer is
//               launched and matched when the DUT raises ack or err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  localparam logic [7:0] TB_TIMEOUT = 8'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_wdat, m1_adr, m1_wdat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [1:0]  grant;
  logic        irq;
  logic [7:0]  tcnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          m;
    bit          err;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  wb_port_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(grant), .timeout_irq_o(irq), .timeout_cnt_o(tcnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_sel = 4'h5; m0_adr = adr; m0_wdat = dat;
    end else begin
      m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_sel = 4'hA; m1_adr = adr; m1_wdat = dat;
    end
  endtask

  // One slave ack cycle returning d; leaves time at posedge+1 after it.
  task automatic slave_ack(input logic [31:0] d);
    @(posedge clk); #1 s_ack = 1'b1; s_rdat = d;
    @(posedge clk); #1 s_ack = 1'b0; s_rdat = 32'd0;
  endtask

  // Single-master transfer from IDLE, ack dly cycles after the grant cycle.
  // Called at posedge+1 with the arbiter idle; returns likewise.
  task automatic xfer(input int m, input logic we, input logic [31:0] adr,
                      input logic [31:0] wdat, input logic [31:0] rdat, input int dly);
    drive_m(m, 1'b1, we, adr, wdat);
    sb.push_back('{m, 1'b0, rdat});
    @(negedge clk); check_eq("pre_grant", grant, 2'b00);
    @(negedge clk); check_eq("grant", grant, (m == 0) ? 2'b01 : 2'b10);
    check_eq("s_adr", s_adr, adr);
    check_eq("s_wdat", s_wdat, wdat);
    check_eq("s_we", s_we, we);
    check_eq("s_sel", s_sel, (m == 0) ? 4'h5 : 4'hA);
    check_eq("s_cyc", s_cyc, 1'b1);
    repeat (dly - 1) @(posedge clk);
    @(posedge clk); #1 s_ack = 1'b1; s_rdat = rdat;
    @(negedge clk); check_eq("nonowner_dat", (m == 0) ? m1_rdat : m0_rdat, 32'd0);
    @(posedge clk); #1 s_ack = 1'b0; s_rdat = 32'd0;
    drive_m(m, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
  endtask

  // Granted strobe that is never acknowledged; expects err after TIMEOUT+1 cycles.
  task automatic timeout_xfer(input int m);
    int cyc_cnt;
    drive_m(m, 1'b1, 1'b0, 32'h0000_0F00, 32'd0);
    sb.push_back('{m, 1'b1, 32'd0});
    @(negedge clk);
    @(negedge clk); check_eq("to_grant", grant, (m == 0) ? 2'b01 : 2'b10);
    cyc_cnt = 0;
    while (cyc_cnt < 20) begin
      @(negedge clk);
      cyc_cnt++;
      if (irq) break;
    end
    check_eq("err_latency", cyc_cnt, TB_TIMEOUT + 8'd1);
    check_eq("err_grant", grant, 2'b00);
    check_eq("err_s_cyc", s_cyc, 1'b0);
    drive_m(m, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    check_eq("irq_one_cycle", irq, 1'b0);
  endtask

  // Response monitor: every ack/err must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [3:0] r;
      r = {m1_err, m1_ack, m0_err, m0_ack};
      if (r != 4'd0) begin
        if (sb.size() == 0) begin
          check_eq("spurious_resp", r, 4'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq("resp_master", (m1_ack | m1_err) ? 1 : 0, e.m);
          check_eq("resp_kind", (m0_err | m1_err) ? 1 : 0, e.err ? 1 : 0);
          check_eq("resp_both", ((m0_ack | m0_err) & (m1_ack | m1_err)) ? 1 : 0, 0);
          check_eq("resp_data", (e.m == 0) ? m0_rdat : m1_rdat, e.dat);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] saved;
    rst_n = 1'b0; s_ack = 1'b0; s_rdat = 32'd0;
    drive_m(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_m(1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_grant", grant, 2'b00);
    check_eq("rst_irq", irq, 1'b0);
    check_eq("rst_tcnt", tcnt, 8'd0);
    check_eq("rst_s_cyc", s_cyc, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Slave ack with nobody granted reaches nobody.
    @(posedge clk); #1 s_ack = 1'b1; s_rdat = 32'hFFFF_FFFF;
    @(negedge clk);
    check_eq("idle_ack", {m1_ack, m0_ack}, 2'b00);
    check_eq("idle_dat", m0_rdat | m1_rdat, 32'd0);
    @(posedge clk); #1 s_ack = 1'b0; s_rdat = 32'd0;

    // First tie goes to m0, m1 follows after one idle cycle.
    drive_m(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
    drive_m(1, 1'b1, 1'b0, 32'h0000_0020, 32'd0);
    sb.push_back('{0, 1'b0, 32'hA0A0_0001});
    sb.push_back('{1, 1'b0, 32'hB0B0_0002});
    @(negedge clk); check_eq("tie_pre", grant, 2'b00);
    @(negedge clk); check_eq("tie1_grant", grant, 2'b01);
    slave_ack(32'hA0A0_0001);
    drive_m(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk); check_eq("tie_hold", grant, 2'b01);
    @(negedge clk); check_eq("tie_gap", grant, 2'b00);
    @(negedge clk); check_eq("tie_m1", grant, 2'b10);
    slave_ack(32'hB0B0_0002);
    drive_m(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    drive_m(0, 1'b1, 1'b0, 32'h0000_0030, 32'd0);
    drive_m(1, 1'b1, 1'b0, 32'h0000_0040, 32'd0);
    sb.push_back('{0, 1'b0, 32'hC0C0_0003});
    @(negedge clk);
    @(negedge clk); check_eq("tie2_grant", grant, 2'b01);
    slave_ack(32'hC0C0_0003);
    drive_m(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive_m(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;

    // Plain transfers, including ack in the cycle the timer reaches TIMEOUT.
    xfer(0, 1'b0, 32'h0000_0100, 32'd0,         32'h1234_5678, 2);
    xfer(1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0000_0000, 1);
    xfer(0, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 32'h5555_AAAA, 3);
    saved = tcnt;
    xfer(1, 1'b0, 32'h0000_0400, 32'd0,         32'h0BAD_CAFE, 4);
    check_eq("ack_wins_tcnt", tcnt, saved);

    // Timeouts.
    timeout_xfer(0);
    check_eq("tcnt_1", tcnt, 8'd1);
    timeout_xfer(1);
    check_eq("tcnt_2", tcnt, 8'd2);

    // Bus lock: m1 keeps cyc with stb low well past TIMEOUT while m0 waits.
    drive_m(1, 1'b1, 1'b0, 32'h0000_0500, 32'd0);
    sb.push_back('{1, 1'b0, 32'h1111_0001});
    @(negedge clk);
    @(negedge clk); check_eq("lock_grant", grant, 2'b10);
    slave_ack(32'h1111_0001);
    m1_stb = 1'b0;
    drive_m(0, 1'b1, 1'b0, 32'h0000_0600, 32'd0);
    repeat (6) @(posedge clk);
    @(negedge clk); check_eq("lock_hold", grant, 2'b10);
    @(posedge clk); #1 m1_stb = 1'b1;
    sb.push_back('{1, 1'b0, 32'h1111_0002});
    slave_ack(32'h1111_0002);
    drive_m(1, 1'b0, 1'b0, 32'd0, 32'd0);
    sb.push_back('{0, 1'b0, 32'h2222_0003});
    @(negedge clk);
    @(negedge clk); check_eq("lock_gap", grant, 2'b00);
    @(negedge clk); check_eq("lock_next", grant, 2'b01);
    slave_ack(32'h2222_0003);
    drive_m(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;

    // Reset during an m1 write: outputs drop without a clock edge.
    drive_m(1, 1'b1, 1'b1, 32'h0000_0700, 32'h7777_7777);
    @(negedge clk);
    @(negedge clk); check_eq("rstx_grant", grant, 2'b10);
    check_eq("rstx_s_cyc", s_cyc, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstx_async_cyc", s_cyc, 1'b0);
    check_eq("rstx_async_grant", grant, 2'b00);
    check_eq("rstx_async_adr", s_adr, 32'd0);
    s_ack = 1'b1; s_rdat = 32'h9999_9999;
    #1;
    check_eq("rstx_no_ack", {m1_err, m1_ack, m0_err, m0_ack}, 4'd0);
    s_ack = 1'b0; s_rdat = 32'd0;
    drive_m(1, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstx_idle", grant, 2'b00);
    check_eq("rstx_tcnt", tcnt, 8'd0);
    @(posedge clk); #1;
    xfer(0, 1'b0, 32'h0000_0800, 32'd0, 32'h8888_0008, 1);

    // Saturation of the timeout counter.
    for (int i = 0; i < 300; i++) begin
      timeout_xfer(i % 2);
    end
    check_eq("tcnt_sat", tcnt, 8'hFF);

    check_eq("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
